// File: rtl/carregador_programa_pkg.sv
// Shared types and constants for the boot-time program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pacote_carregador;

    typedef enum logic [2:0] {
        CAB0,
        CAB1,
        RECEBE,
        ESCREVE,
        CHK,
        FIM,
        ERRO
    } estado_t;

    localparam int          BYTES_CAB     = 2;
    localparam int          BYTES_PALAVRA = 4;
    localparam logic [31:0] INSTR_BOLHA   = 32'd0;

    // Width of the word-count field carried in the image header
    localparam int          LARGURA_N     = 8 * BYTES_CAB;

endpackage

// File: rtl/carregador_programa_montador_palavra.sv
// Packs an MSB-first byte stream into 32-bit words.
// Latency: palavra_cheia flags the 4th byte combinationally; the word is registered one cycle later.
// Backpressure: none of its own; only counts bytes the parent actually accepted.
module montador_palavra
    import pacote_carregador::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_dado,
    input  logic        aceita,
    input  logic        limpa,
    output logic [31:0] palavra,
    output logic        palavra_cheia
);

    localparam int LARGURA_CONT = $clog2(BYTES_PALAVRA);

    logic [31:0]             palavra_q, palavra_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;

    // Shift in each accepted byte; clearing wins so a fresh word starts after every write
    always_comb begin
        palavra_d = palavra_q;
        cont_d    = cont_q;
        if (limpa) begin
            palavra_d = '0;
            cont_d    = '0;
        end else if (aceita) begin
            palavra_d = {palavra_q[23:0], byte_dado};
            cont_d    = cont_q + LARGURA_CONT'(1);
        end
    end

    // Shift register and byte counter, synchronous active-low clear
    always_ff @(posedge clock) begin
        if (!reset) begin
            palavra_q <= '0;
            cont_q    <= '0;
        end else begin
            palavra_q <= palavra_d;
            cont_q    <= cont_d;
        end
    end

    assign palavra       = palavra_q;
    assign palavra_cheia = aceita && (cont_q == LARGURA_CONT'(BYTES_PALAVRA - 1));

endmodule

// File: rtl/carregador_programa.sv
// Boot loader: receives an image byte stream, writes it to instruction memory, then hands the port to the CPU.
// Latency: write strobe one cycle after the 4th byte of a word; CPU read path is combinational once loaded.
// Backpressure: byte_pronto drops during the write cycle and in FIM/ERRO. Optional CARREGADOR_CHECKSUM_EN adds a trailing XOR check byte.
module carregador_programa
    import pacote_carregador::*;
#(
    parameter int NUM_PALAVRAS = 141,
    parameter int LARGURA_END  = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             byte_dado,
    input  logic                   byte_valido,
    output logic                   byte_pronto,
    input  logic [31:0]            cpu_endereco,
    output logic [31:0]            cpu_instrucao,
    output logic                   cpu_parado,
    output logic [LARGURA_END-1:0] mem_endereco,
    output logic                   mem_escrita,
    output logic [31:0]            mem_dado,
    input  logic [31:0]            mem_instrucao,
    output logic                   carga_concluida,
    output logic                   erro
);

`ifdef CARREGADOR_CHECKSUM_EN
    localparam estado_t APOS_CARGA = CHK;
`else
    localparam estado_t APOS_CARGA = FIM;
`endif

    estado_t                estado_q, estado_d;
    logic [LARGURA_N-1:0]   n_q, n_d;
    logic [LARGURA_END-1:0] ptr_q, ptr_d;

    logic                   transf;
    logic [LARGURA_N-1:0]   n_cab;
    logic [LARGURA_N-1:0]   ptr_prox_ext;
    logic [31:0]            palavra;
    logic                   palavra_cheia;

    // Upper fetch-address bits do not reach the memory
    logic                   endereco_alto_unused;
    assign endereco_alto_unused = ^cpu_endereco[31:LARGURA_END];

    assign transf       = byte_valido && byte_pronto;
    assign n_cab        = {n_q[LARGURA_N-1:8], byte_dado};
    assign ptr_prox_ext = LARGURA_N'(ptr_q) + LARGURA_N'(1);

    montador_palavra u_montador (
        .clock         (clock),
        .reset         (reset),
        .byte_dado     (byte_dado),
        .aceita        (transf && (estado_q == RECEBE)),
        .limpa         (estado_q == ESCREVE),
        .palavra       (palavra),
        .palavra_cheia (palavra_cheia)
    );

`ifdef CARREGADOR_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    // Running XOR over header and word bytes
    always_comb begin
        chk_d = chk_q;
        if (transf && (estado_q == CAB0 || estado_q == CAB1 || estado_q == RECEBE)) begin
            chk_d = chk_q ^ byte_dado;
        end
    end

    // Checksum accumulator register
    always_ff @(posedge clock) begin
        if (!reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    // Next-state, header capture and write-pointer advance
    always_comb begin
        estado_d = estado_q;
        n_d      = n_q;
        ptr_d    = ptr_q;
        case (estado_q)
            CAB0: begin
                if (transf) begin
                    n_d[LARGURA_N-1:8] = byte_dado;
                    estado_d           = CAB1;
                end
            end
            CAB1: begin
                if (transf) begin
                    n_d[7:0] = byte_dado;
                    if (n_cab == '0) begin
                        estado_d = APOS_CARGA;
                    end else if (n_cab > LARGURA_N'(NUM_PALAVRAS)) begin
                        estado_d = ERRO;
                    end else begin
                        estado_d = RECEBE;
                    end
                end
            end
            RECEBE: begin
                if (palavra_cheia) begin
                    estado_d = ESCREVE;
                end
            end
            ESCREVE: begin
                // Pointer stops at N-1 so it can never wrap
                if (ptr_prox_ext == n_q) begin
                    estado_d = APOS_CARGA;
                end else begin
                    ptr_d    = ptr_q + LARGURA_END'(1);
                    estado_d = RECEBE;
                end
            end
`ifdef CARREGADOR_CHECKSUM_EN
            CHK: begin
                if (transf) begin
                    estado_d = (byte_dado == chk_q) ? FIM : ERRO;
                end
            end
`endif
            default: begin
                estado_d = estado_q;
            end
        endcase
    end

    // State, word count and pointer registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= CAB0;
            n_q      <= '0;
            ptr_q    <= '0;
        end else begin
            estado_q <= estado_d;
            n_q      <= n_d;
            ptr_q    <= ptr_d;
        end
    end

    // Handshake, write port and CPU/loader arbitration
    always_comb begin
        byte_pronto     = 1'b0;
        mem_escrita     = 1'b0;
        mem_dado        = 32'd0;
        mem_endereco    = ptr_q;
        cpu_instrucao   = INSTR_BOLHA;
        cpu_parado      = 1'b1;
        carga_concluida = 1'b0;
        erro            = 1'b0;
        case (estado_q)
            CAB0, CAB1, RECEBE, CHK: begin
                byte_pronto = reset;
            end
            ESCREVE: begin
                mem_escrita = 1'b1;
                mem_dado    = palavra;
            end
            FIM: begin
                mem_endereco    = cpu_endereco[LARGURA_END-1:0];
                cpu_instrucao   = mem_instrucao;
                cpu_parado      = 1'b0;
                carga_concluida = 1'b1;
            end
            ERRO: begin
                erro = 1'b1;
            end
            default: begin
                byte_pronto = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: scoreboard of expected memory writes plus per-scenario checks.
// Latency: n/a.
// Backpressure: source holds an offered byte until it is accepted.
module tb_carregador_programa;

    localparam int LE = 10;

    typedef struct {
        logic [LE-1:0] end_esp;
        logic [31:0]   dado_esp;
    } escrita_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    byte_dado = 8'd0;
    logic          byte_valido = 1'b0;
    logic          byte_pronto;
    logic [31:0]   cpu_endereco = 32'd0;
    logic [31:0]   cpu_instrucao;
    logic          cpu_parado;
    logic [LE-1:0] mem_endereco;
    logic          mem_escrita;
    logic [31:0]   mem_dado;
    logic [31:0]   mem_instrucao;
    logic          carga_concluida;
    logic          erro;

    logic [31:0]   mem [0:(1<<LE)-1];
    escrita_t      esperado_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_escrita) mem[mem_endereco] <= mem_dado;
    end
    assign mem_instrucao = mem[mem_endereco];

    carregador_programa #(.NUM_PALAVRAS(141), .LARGURA_END(LE)) dut (
        .clock           (clock),
        .reset           (reset),
        .byte_dado       (byte_dado),
        .byte_valido     (byte_valido),
        .byte_pronto     (byte_pronto),
        .cpu_endereco    (cpu_endereco),
        .cpu_instrucao   (cpu_instrucao),
        .cpu_parado      (cpu_parado),
        .mem_endereco    (mem_endereco),
        .mem_escrita     (mem_escrita),
        .mem_dado        (mem_dado),
        .mem_instrucao   (mem_instrucao),
        .carga_concluida (carga_concluida),
        .erro            (erro)
    );

    function automatic logic [7:0] xor_de(input logic [7:0] img[$]);
        logic [7:0] x = 8'd0;
        foreach (img[i]) x = x ^ img[i];
        return x;
    endfunction

    // Streams an image; expected writes are pushed as bytes are accepted and popped when the DUT writes.
    task automatic envia_imagem(input logic [7:0] img[$], input bit lacunas, input int ciclos_max,
                                output int aceitos, output int escritas);
        int         idx = 0;
        int         n_img = 0;
        int         k;
        int         resto = 0;
        bit         aceito = 1'b0;
        logic [31:0] acum = 32'd0;
        escrita_t   e;
        aceitos  = 0;
        escritas = 0;
        for (int c = 0; c < ciclos_max; c++) begin
            @(negedge clock);
            if (aceito) begin
                if (idx == 0) begin
                    n_img = int'(img[0]) << 8;
                end else if (idx == 1) begin
                    n_img = n_img | int'(img[1]);
                end else begin
                    k = idx - 2;
                    if (k < 4 * n_img && n_img <= 141) begin
                        acum = {acum[23:0], img[idx]};
                        if (k % 4 == 3) begin
                            e.end_esp  = LE'(k / 4);
                            e.dado_esp = acum;
                            esperado_q.push_back(e);
                        end
                    end
                end
                idx++;
                aceitos++;
            end
            if (mem_escrita) begin
                escritas++;
                n_cmp++;
                if (esperado_q.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected: got addr %0d data %h, required no write", mem_endereco, mem_dado);
                end else begin
                    e = esperado_q.pop_front();
                    if (mem_endereco !== e.end_esp || mem_dado !== e.dado_esp) begin
                        n_err++;
                        $display("FAIL write_data: got addr %0d data %h, required addr %0d data %h",
                                 mem_endereco, mem_dado, e.end_esp, e.dado_esp);
                    end
                end
                n_cmp++;
                if (byte_pronto !== 1'b0) begin
                    n_err++;
                    $display("FAIL ready_in_write: got byte_pronto %b, required 0", byte_pronto);
                end
            end
            if (!(byte_valido && !aceito)) begin
                if (idx < img.size() && !(lacunas && $urandom_range(0, 3) == 0)) begin
                    byte_valido = 1'b1;
                    byte_dado   = img[idx];
                end else begin
                    byte_valido = 1'b0;
                end
            end
            aceito = byte_valido && byte_pronto;
            if (idx == img.size()) resto++;
            if (resto >= 4) break;
        end
        byte_valido = 1'b0;
        n_cmp++;
        if (esperado_q.size() != 0) begin
            n_err++;
            $display("FAIL writes_missing: got %0d outstanding, required 0", esperado_q.size());
        end
        esperado_q.delete();
    endtask

    task automatic aplica_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (byte_pronto !== 1'b0 || cpu_parado !== 1'b1 || mem_escrita !== 1'b0 || erro !== 1'b0 ||
            carga_concluida !== 1'b0 || cpu_instrucao !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got pronto %b parado %b escrita %b erro %b concl %b instr %h, required 0 1 0 0 0 0",
                     byte_pronto, cpu_parado, mem_escrita, erro, carga_concluida, cpu_instrucao);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if (byte_pronto !== 1'b1 || mem_endereco !== '0) begin
            n_err++;
            $display("FAIL reset_release: got pronto %b addr %0d, required 1 0", byte_pronto, mem_endereco);
        end
    endtask

    task automatic test_carga_basica();
        logic [7:0] img[$] = '{8'h00, 8'h02, 8'hC8, 8'h40, 8'h00, 8'h02, 8'hC0, 8'h40, 8'h00, 8'h02};
        int a, w;
`ifdef CARREGADOR_CHECKSUM_EN
        img.push_back(xor_de(img));
`endif
        aplica_reset();
        envia_imagem(img, 1'b1, 300, a, w);
        n_cmp++;
        if (a != img.size() || w != 2) begin
            n_err++;
            $display("FAIL basic_counts: got %0d bytes %0d writes, required %0d 2", a, w, img.size());
        end
        n_cmp++;
        if (carga_concluida !== 1'b1 || cpu_parado !== 1'b0 || erro !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: got concl %b parado %b erro %b, required 1 0 0", carga_concluida, cpu_parado, erro);
        end
        cpu_endereco = 32'd1;
        #1;
        n_cmp++;
        if (cpu_instrucao !== 32'hC0400002 || mem_endereco !== LE'(1)) begin
            n_err++;
            $display("FAIL basic_fetch1: got instr %h addr %0d, required c0400002 1", cpu_instrucao, mem_endereco);
        end
        cpu_endereco = 32'd0;
        #1;
        n_cmp++;
        if (cpu_instrucao !== 32'hC8400002) begin
            n_err++;
            $display("FAIL basic_fetch0: got %h, required c8400002", cpu_instrucao);
        end
    endtask

    task automatic test_cabecalho_invalido();
        logic [7:0] img[$] = '{8'h00, 8'hC8, 8'h11, 8'h22, 8'h33, 8'h44};
        int a, w;
        aplica_reset();
        envia_imagem(img, 1'b0, 40, a, w);
        n_cmp++;
        if (a != 2 || w != 0) begin
            n_err++;
            $display("FAIL hdr_counts: got %0d bytes %0d writes, required 2 0", a, w);
        end
        n_cmp++;
        if (erro !== 1'b1 || byte_pronto !== 1'b0 || cpu_parado !== 1'b1 || carga_concluida !== 1'b0) begin
            n_err++;
            $display("FAIL hdr_error: got erro %b pronto %b parado %b concl %b, required 1 0 1 0",
                     erro, byte_pronto, cpu_parado, carga_concluida);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] img[$] = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                               8'h99, 8'hAA, 8'hBB, 8'hCC};
        int a, w;
`ifdef CARREGADOR_CHECKSUM_EN
        img.push_back(xor_de(img));
`endif
        aplica_reset();
        envia_imagem(img, 1'b0, 200, a, w);
        n_cmp++;
        if (a != img.size() || w != 3 || carga_concluida !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_counts: got %0d bytes %0d writes concl %b, required %0d 3 1", a, w, carga_concluida, img.size());
        end
        cpu_endereco = 32'd2;
        #1;
        n_cmp++;
        if (cpu_instrucao !== 32'h99AABBCC) begin
            n_err++;
            $display("FAIL b2b_fetch2: got %h, required 99aabbcc", cpu_instrucao);
        end
        cpu_endereco = 32'd0;
    endtask

    task automatic test_reset_meio_carga();
        logic [7:0] parcial[$] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [7:0] img[$] = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        int a, w;
`ifdef CARREGADOR_CHECKSUM_EN
        img.push_back(xor_de(img));
`endif
        aplica_reset();
        envia_imagem(parcial, 1'b0, 30, a, w);
        n_cmp++;
        if (a != 6 || w != 1) begin
            n_err++;
            $display("FAIL mid_partial: got %0d bytes %0d writes, required 6 1", a, w);
        end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (byte_pronto !== 1'b0 || mem_endereco !== '0 || cpu_parado !== 1'b1) begin
            n_err++;
            $display("FAIL mid_in_reset: got pronto %b addr %0d parado %b, required 0 0 1", byte_pronto, mem_endereco, cpu_parado);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if (byte_pronto !== 1'b1 || mem_endereco !== '0 || carga_concluida !== 1'b0) begin
            n_err++;
            $display("FAIL mid_after_reset: got pronto %b addr %0d concl %b, required 1 0 0", byte_pronto, mem_endereco, carga_concluida);
        end
        envia_imagem(img, 1'b1, 300, a, w);
        n_cmp++;
        if (a != img.size() || w != 2 || carga_concluida !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reload: got %0d bytes %0d writes concl %b, required %0d 2 1", a, w, carga_concluida, img.size());
        end
        cpu_endereco = 32'd0;
        #1;
        n_cmp++;
        if (cpu_instrucao !== 32'h01234567) begin
            n_err++;
            $display("FAIL mid_fetch0: got %h, required 01234567", cpu_instrucao);
        end
    endtask

`ifdef CARREGADOR_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] bom[$] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic [7:0] mau[$] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        int a, w;
        aplica_reset();
        envia_imagem(bom, 1'b0, 60, a, w);
        n_cmp++;
        if (carga_concluida !== 1'b1 || erro !== 1'b0 || w != 1) begin
            n_err++;
            $display("FAIL chk_good: got concl %b erro %b writes %0d, required 1 0 1", carga_concluida, erro, w);
        end
        aplica_reset();
        envia_imagem(mau, 1'b0, 60, a, w);
        n_cmp++;
        if (erro !== 1'b1 || cpu_parado !== 1'b1 || carga_concluida !== 1'b0) begin
            n_err++;
            $display("FAIL chk_bad: got erro %b parado %b concl %b, required 1 1 0", erro, cpu_parado, carga_concluida);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_carga_basica();
        test_cabecalho_invalido();
        test_back_to_back();
        test_reset_meio_carga();
`ifdef CARREGADOR_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
